dma_bus_arbiter: RTL and testbench
==================================

DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum GRANT-state cycles allowed before dma_end.
REQ-002 Parameter QDEPTH_W, default 2: width of the pending-request counter (max 3 queued).
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 dev_int  input  1  one-cycle pulse from the external device: a 4-word block is ready.
REQ-006 cpu_mem_busy  input  1  CPU currently owns the data-memory bus for an access in flight.
REQ-007 BR  input  1  bus request from the DMA engine.
REQ-008 dma_end  input  1  end-of-transfer interrupt from the DMA engine.
REQ-009 cmd  output  1  DMA start command to the DMA engine; level signal.
REQ-010 BG  output  1  bus grant to the DMA engine and the CPU; registered.
REQ-011 cpu_stall  output  1  CPU must not start a memory access; equals the registered (state != IDLE).
REQ-012 dma_done_irq  output  1  one-cycle pulse to the CPU on successful transfer completion.
REQ-013 dma_err  output  1  one-cycle pulse to the CPU on timeout abort.
REQ-014 q_overflow  output  1  sticky flag: a dev_int was dropped because the queue was full.

Function
REQ-015 FSM states: IDLE, REQ, GRANT, RELEASE; encoding is free.
REQ-016 IDLE: dev_int=1 or pending>0 -> REQ next cycle; dev_int takes priority and is not enqueued.
REQ-017 REQ: cmd=1, BG=0; BR=1 and cpu_mem_busy=0 in the same cycle -> GRANT next cycle; otherwise stay.
REQ-018 GRANT: cmd=1, BG=1; the watchdog counter increments each cycle from 0.
REQ-019 GRANT: dma_end=1 -> RELEASE next cycle with done status; this has priority over timeout in the same cycle.
REQ-020 GRANT: watchdog reaches TIMEOUT-1 with dma_end=0 -> RELEASE next cycle with error status.
REQ-021 RELEASE lasts exactly one cycle: cmd=0, BG=0; dma_done_irq=1 for done status, dma_err=1 for error status.
REQ-022 RELEASE -> REQ if pending>0, and pending decrements; otherwise -> IDLE.
REQ-023 BG is 0 in every state other than GRANT.
REQ-024 BG rises exactly one cycle after the REQ-state grant condition holds.
REQ-025 dev_int outside IDLE: pending increments, saturating at 2^QDEPTH_W-1.
REQ-026 dev_int arriving when pending is at max: pending is unchanged and q_overflow is set.
REQ-027 dev_int in RELEASE coinciding with a dequeue: pending is unchanged net.
REQ-028 Request-to-grant latency with cpu_mem_busy=0: dev_int at cycle t, cmd=1 at t+1, BG=1 at t+2.
REQ-029 A dma_end level that persists after BG falls is ignored outside GRANT.

Reset
REQ-030 reset_n=0 at a rising edge forces state=IDLE.
REQ-031 reset_n=0 at a rising edge clears pending, watchdog and q_overflow.
REQ-032 reset_n=0 at a rising edge forces cmd=0, BG=0, cpu_stall=0, dma_done_irq=0, dma_err=0.
REQ-033 Reset asserted mid-GRANT drops BG and cmd on the same edge and emits no irq or error pulse.

Structure
REQ-034 The shared package holds the FSM state typedef, the `WORD_SIZE/`FETCH_SIZE constants and the TIMEOUT default.
REQ-035 The watchdog is one sub-module, dma_watchdog: clear/enable inputs and an expire output, parameterised by TIMEOUT.

Verification
REQ-036 Basic transfer: dev_int at t, BR=cmd, dma_end at t+14 -> BG high t+2..t+14, dma_done_irq at t+15, IDLE at t+16.
REQ-037 CPU contention: cpu_mem_busy=1 for cycles t+1..t+4 -> BG held 0 until t+6; cpu_stall=1 from t+1.
REQ-038 Queueing: 4 dev_int pulses during one GRANT -> pending=3, q_overflow=1, then three back-to-back transfers, each RELEASE->REQ.
REQ-039 Timeout: dma_end never asserted -> dma_err pulse after 16 GRANT cycles, BG=0, no dma_done_irq.
REQ-040 Reset mid-GRANT: reset_n=0 for one edge -> BG=0, cmd=0, pending=0 next cycle, no pulses.
REQ-041 Simultaneous events: dma_end on the TIMEOUT-1 cycle -> dma_done_irq only; dev_int in RELEASE with pending=1 -> pending stays 1.

Source files
------------

// File: rtl/dma_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// dma_bus_arbiter_pkg : shared types and constants for the DMA bus arbiter
// Rev 1.0
// ============================================================================
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef FETCH_SIZE
`define FETCH_SIZE 4
`endif

package dma_bus_arbiter_pkg;
  localparam int c_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/dma_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// dma_bus_arbiter_if : handshake bundle between CPU/device/DMA and arbiter
// Rev 1.0
// ============================================================================
interface dma_bus_arbiter_if;
  logic dev_int;
  logic cpu_mem_busy;
  logic BR;
  logic dma_end;
  logic cmd;
  logic BG;
  logic cpu_stall;
  logic dma_done_irq;
  logic dma_err;
  logic q_overflow;

  modport slave (
    input  dev_int, cpu_mem_busy, BR, dma_end,
    output cmd, BG, cpu_stall, dma_done_irq, dma_err, q_overflow
  );

  modport master (
    output dev_int, cpu_mem_busy, BR, dma_end,
    input  cmd, BG, cpu_stall, dma_done_irq, dma_err, q_overflow
  );
endinterface
`default_nettype wire

// File: rtl/dma_bus_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// dma_watchdog : counts enabled cycles from 0, flags the TIMEOUT-1 cycle
// Rev 1.0
// ============================================================================
module dma_watchdog
  import dma_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = c_TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int              c_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_W-1:0]  c_LAST = c_W'(TIMEOUT - 1);

  logic [c_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!reset_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// dma_bus_arbiter : hands the data-memory bus to the DMA engine per device block
// Rev 1.0
// ============================================================================
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT  = c_TIMEOUT_DEF,
  parameter int QDEPTH_W = 2
) (
  input  logic              CLK,
  input  logic              reset_n,
  dma_bus_arbiter_if.slave  bus
);
  localparam logic [QDEPTH_W-1:0] c_QMAX = '1;

  state_t              r_state;
  logic [QDEPTH_W-1:0] r_pending;
  logic                r_cmd;
  logic                r_bg;
  logic                r_stall;
  logic                r_done;
  logic                r_err;
  logic                r_ovf;
  logic                w_expire;
  logic                w_enq;
  logic                w_deq;

  // A dev_int seen in IDLE starts service directly and is never queued.
  assign w_enq = bus.dev_int && (r_state != S_IDLE);
  assign w_deq = (r_pending != '0) &&
                 ((r_state == S_RELEASE) || ((r_state == S_IDLE) && !bus.dev_int));

  dma_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .i_clr    (r_state != S_GRANT),
    .i_en     (r_state == S_GRANT),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_cmd     <= 1'b0;
      r_bg      <= 1'b0;
      r_stall   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      if (w_enq && !w_deq) begin
        if (r_pending == c_QMAX) r_ovf <= 1'b1;
        else                     r_pending <= r_pending + 1'b1;
      end else if (w_deq && !w_enq) begin
        r_pending <= r_pending - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.dev_int || (r_pending != '0)) begin
            r_state <= S_REQ;
            r_cmd   <= 1'b1;
            r_stall <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.BR && !bus.cpu_mem_busy) begin
            r_state <= S_GRANT;
            r_bg    <= 1'b1;
          end
        end
        S_GRANT: begin
          // dma_end wins over a watchdog expiry in the same cycle
          if (bus.dma_end || w_expire) begin
            r_state <= S_RELEASE;
            r_cmd   <= 1'b0;
            r_bg    <= 1'b0;
            r_done  <= bus.dma_end;
            r_err   <= !bus.dma_end;
          end
        end
        S_RELEASE: begin
          if (r_pending != '0) begin
            r_state <= S_REQ;
            r_cmd   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_stall <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cmd   <= 1'b0;
          r_bg    <= 1'b0;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd          = r_cmd;
  assign bus.BG           = r_bg;
  assign bus.cpu_stall    = r_stall;
  assign bus.dma_done_irq = r_done;
  assign bus.dma_err      = r_err;
  assign bus.q_overflow   = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dma_bus_arbiter : directed scenarios plus random traffic vs. a cycle model
// Rev 1.0
// ============================================================================
module tb_dma_bus_arbiter;
  localparam int TIMEOUT  = 16;
  localparam int QDEPTH_W = 2;
  localparam int QMAX     = (1 << QDEPTH_W) - 1;

  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLK = ~CLK;

  dma_bus_arbiter_if bus();

  dma_bus_arbiter #(.TIMEOUT(TIMEOUT), .QDEPTH_W(QDEPTH_W)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: phase 0=idle 1=requesting 2=owning bus 3=handing back
  int m_phase = 0;
  int m_pend  = 0;
  int m_gcyc  = 0;
  bit m_ovf   = 1'b0;
  bit m_done  = 1'b0;
  bit m_err   = 1'b0;

  function automatic void model_tick(input bit rst_n, input bit dev, input bit busy,
                                     input bit br, input bit dend);
    int  nph;
    int  enq;
    int  take;
    if (!rst_n) begin
      m_phase = 0; m_pend = 0; m_gcyc = 0; m_ovf = 0; m_done = 0; m_err = 0;
      return;
    end
    nph    = m_phase;
    take   = 0;
    m_done = 0;
    m_err  = 0;
    enq    = (dev && m_phase != 0) ? 1 : 0;
    case (m_phase)
      0: if (dev) nph = 1; else if (m_pend > 0) begin nph = 1; take = 1; end
      1: if (br && !busy) nph = 2;
      2: if (dend) begin nph = 3; m_done = 1; end
         else if (m_gcyc == TIMEOUT - 1) begin nph = 3; m_err = 1; end
      default: begin nph = (m_pend > 0) ? 1 : 0; take = (m_pend > 0) ? 1 : 0; end
    endcase
    m_pend = m_pend + enq - take;
    if (m_pend > QMAX) begin m_pend = QMAX; m_ovf = 1; end
    m_gcyc  = (m_phase == 2 && nph == 2) ? m_gcyc + 1 : 0;
    m_phase = nph;
  endfunction

  function automatic logic [5:0] exp_vec();
    return {(m_phase == 1 || m_phase == 2), (m_phase == 2), (m_phase != 0),
            m_done, m_err, m_ovf};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {bus.cmd, bus.BG, bus.cpu_stall, bus.dma_done_irq, bus.dma_err, bus.q_overflow};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drv(input bit dev, input bit busy, input bit br, input bit dend);
    bus.dev_int      = dev;
    bus.cpu_mem_busy = busy;
    bus.BR           = br;
    bus.dma_end      = dend;
  endtask

  // Advance one cycle; outputs {cmd,BG,stall,done,err,ovf} checked at negedge
  task automatic step();
    @(posedge CLK);
    model_tick(reset_n, bus.dev_int, bus.cpu_mem_busy, bus.BR, bus.dma_end);
    @(negedge CLK);
    chk("model_cmd_bg_stall_done_err_ovf", {2'b0, dut_vec()}, {2'b0, exp_vec()});
  endtask

  initial begin
    int g;
    drv(0, 0, 0, 0);
    reset_n = 1'b0;
    step(); step();
    chk("reset_cmd", bus.cmd, 0);
    chk("reset_bg", bus.BG, 0);
    chk("reset_stall", bus.cpu_stall, 0);
    chk("reset_ovf", bus.q_overflow, 0);
    reset_n = 1'b1;

    // Basic transfer: dev_int at t, dma_end at t+14
    drv(1, 0, 1, 0); step();
    chk("basic_cmd_t1", bus.cmd, 1);
    chk("basic_bg_t1", bus.BG, 0);
    drv(0, 0, 1, 0); step();
    chk("basic_bg_t2", bus.BG, 1);
    for (int k = 3; k <= 14; k++) step();
    chk("basic_bg_t14", bus.BG, 1);
    drv(0, 0, 1, 1); step();
    chk("basic_done_t15", bus.dma_done_irq, 1);
    chk("basic_bg_t15", bus.BG, 0);
    drv(0, 0, 0, 1); step();
    chk("basic_stall_t16", bus.cpu_stall, 0);
    chk("basic_done_t16", bus.dma_done_irq, 0);
    drv(0, 0, 0, 0); step();

    // CPU contention: busy during t+1..t+4
    drv(1, 0, 1, 0); step();
    chk("cont_stall_t1", bus.cpu_stall, 1);
    drv(0, 1, 1, 0);
    for (int c = 1; c <= 4; c++) begin
      chk("cont_bg_low", bus.BG, 0);
      step();
    end
    drv(0, 0, 1, 0);
    chk("cont_bg_t5", bus.BG, 0);
    step();
    chk("cont_bg_t6", bus.BG, 1);
    drv(0, 0, 1, 1); step();
    drv(0, 0, 0, 0); step();

    // Queueing: four dev_int pulses during one grant
    drv(1, 0, 1, 0); step();
    drv(0, 0, 1, 0); step();
    for (int p = 0; p < 4; p++) begin
      drv(1, 0, 1, 0); step();
      drv(0, 0, 1, 0); step();
    end
    chk("queue_ovf", bus.q_overflow, 1);
    for (int n = 0; n < 4; n++) begin
      drv(0, 0, 1, 1); step();
      chk("queue_done", bus.dma_done_irq, 1);
      drv(0, 0, 1, 0); step();
      chk("queue_rel_to_req", bus.cmd, (n < 3) ? 1 : 0);
      if (n < 3) begin
        step();
        chk("queue_regrant", bus.BG, 1);
      end
    end
    chk("queue_idle", bus.cpu_stall, 0);

    // Timeout: dma_end never arrives
    drv(1, 0, 1, 0); step();
    drv(0, 0, 1, 0); step();
    g = 0;
    while (bus.BG === 1'b1 && g < 40) begin
      g++;
      step();
    end
    chk("tmo_grant_cycles", g[7:0], 8'd16);
    chk("tmo_err", bus.dma_err, 1);
    chk("tmo_no_done", bus.dma_done_irq, 0);
    drv(0, 0, 0, 0); step();

    // Reset mid-grant with one request queued
    drv(1, 0, 1, 0); step();
    drv(0, 0, 1, 0); step();
    drv(1, 0, 1, 0); step();
    drv(0, 0, 1, 0); reset_n = 1'b0; step(); reset_n = 1'b1;
    chk("rst_bg", bus.BG, 0);
    chk("rst_cmd", bus.cmd, 0);
    chk("rst_pulses", {bus.dma_done_irq, bus.dma_err}, 0);
    chk("rst_ovf", bus.q_overflow, 0);
    drv(0, 0, 0, 0); step(); step();
    chk("rst_pending_cleared", bus.cpu_stall, 0);

    // dma_end on the last watchdog cycle wins over timeout
    drv(1, 0, 1, 0); step();
    drv(0, 0, 1, 0); step();
    for (int k = 1; k < TIMEOUT; k++) step();
    chk("simul_bg_last", bus.BG, 1);
    drv(0, 0, 1, 1); step();
    chk("simul_done", bus.dma_done_irq, 1);
    chk("simul_no_err", bus.dma_err, 0);
    drv(0, 0, 1, 0); step();

    // dev_int in RELEASE with pending=1 keeps pending at 1
    drv(1, 0, 1, 0); step();
    drv(0, 0, 1, 0); step();
    drv(1, 0, 1, 0); step();
    drv(0, 0, 1, 1); step();
    drv(1, 0, 1, 0); step();
    chk("relq_req1", bus.cmd, 1);
    drv(0, 0, 1, 0); step();
    drv(0, 0, 1, 1); step();
    drv(0, 0, 1, 0); step();
    chk("relq_req2", bus.cmd, 1);
    step();
    drv(0, 0, 1, 1); step();
    drv(0, 0, 1, 0); step();
    chk("relq_idle", bus.cpu_stall, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      drv($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      step();
    end
    reset_n = 1'b1;
    drv(0, 0, 0, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
